add_mp_seq: RTL

- Multi-precision add sequencer.
- Accepts operand word pairs (least-significant word first) on a valid/ready stream, one word per beat.
- Adds each pair plus the carry held from the previous word, and emits sum words on a registered valid/ready output stream.
- Sits directly upstream of result consumers and wraps a single-word adder slice, so operands wider than Bits are added over successive cycles.

---
 rtl/add_pkg.sv | 13 +
 rtl/add_slice_cin.sv | 14 +
 rtl/add_mp_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types for the multi-precision add sequencer
package add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DefaultBits     = 64;
    localparam int DefaultMaxWords = 16;
    localparam int DefaultIdxBits  = 4;

endpackage

// File: rtl/add_slice_cin.sv
// rtl/add_slice_cin.sv - single-word adder slice with carry-in and carry-out
module add_slice_cin #(
    parameter int Bits = 64
) (
    input  logic [Bits-1:0] a_i,
    input  logic [Bits-1:0] b_i,
    input  logic            cin_i,
    output logic [Bits-1:0] sum_o,
    output logic            cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{Bits{1'b0}}, cin_i};

endmodule

// File: rtl/add_mp_seq.sv
// rtl/add_mp_seq.sv - multi-precision add sequencer, LS word first, one word per beat
module add_mp_seq
    import add_pkg::*;
#(
    parameter int Bits     = DefaultBits,
    parameter int MaxWords = DefaultMaxWords,
    parameter int IdxBits  = DefaultIdxBits
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Bits-1:0]    in_a,
    input  logic [Bits-1:0]    in_b,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Bits-1:0]    out_sum,
    output logic [IdxBits-1:0] out_idx,
    output logic               out_last,
    output logic               out_carry,
    output logic               out_err
);

    typedef struct packed {
        logic [Bits-1:0]    sum;
        logic [IdxBits-1:0] idx;
        logic               last;
        logic               carry;
        logic               err;
    } beat_t;

    state_t             state_q, state_d;
    logic [IdxBits-1:0] cnt_q, cnt_d;
    logic               carry_q, carry_d;
    beat_t              out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               cin;
    logic [Bits-1:0]    slice_sum;
    logic               slice_cout;
    logic               at_max;
    logic               term;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cin      = (state_q == RUN) ? carry_q : 1'b0;
    assign at_max   = (cnt_q == IdxBits'(MaxWords - 1));
    assign term     = in_last || at_max;

    add_slice_cin #(.Bits(Bits)) u_slice (
        .a_i    (in_a),
        .b_i    (in_b),
        .cin_i  (cin),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d.sum   = slice_sum;
            out_d.idx   = cnt_q;
            out_d.last  = term;
            out_d.carry = term && slice_cout;
            out_d.err   = at_max && !in_last;
            // A forced stop at MaxWords starts a fresh operation with the next word.
            if (term) begin
                state_d = IDLE;
                cnt_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = RUN;
                cnt_d   = cnt_q + 1'b1;
                carry_d = slice_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_q.sum;
    assign out_idx   = out_q.idx;
    assign out_last  = out_q.last;
    assign out_carry = out_q.carry;
    assign out_err   = out_q.err;

endmodule
